// File: rtl/stage2_q_pack_arb_pkg.sv
// Shared quote-record and message layout constants for the stage 2 quote packer.
// Raw record is LSB-first by arrival order; the message is MSB-first for stage 3.
package stage2_q_pack_arb_pkg;

  localparam int DEF_N_CH  = 3;
  localparam int DEF_DEPTH = 2;

  localparam int MAX_ORIGINAL_DATA_BITS      = 200;
  localparam int MAX_MESSAGE_BITS            = 224;
  localparam int message_head_reserved_width = 8;
  localparam int q_rest_bits                 = 16;

  typedef struct packed {
    logic [15:0] offer_size;
    logic [31:0] offer_price;
    logic [15:0] bid_size;
    logic [31:0] bid_price;
    logic [31:0] strike_price;
    logic [15:0] expiration_block;
    logic [31:0] security_symbol;
    logic [7:0]  message_type;
    logic [7:0]  message_category;
    logic [7:0]  participant_id;
  } q_raw_t;

  typedef struct packed {
    logic [7:0]                               participant_id;
    logic [7:0]                               message_category;
    logic [7:0]                               message_type;
    logic [message_head_reserved_width-1:0]   reserved;
    logic [31:0]                              security_symbol;
    logic [15:0]                              expiration_block;
    logic [31:0]                              strike_price;
    logic [31:0]                              bid_price;
    logic [15:0]                              bid_size;
    logic [31:0]                              offer_price;
    logic [15:0]                              offer_size;
    logic [q_rest_bits-1:0]                   rest;
  } q_msg_t;

endpackage

// File: rtl/stage2_q_field_pack.sv
// Pure combinational repack of one raw quote record into the stage 3 message layout.
module stage2_q_field_pack
  import stage2_q_pack_arb_pkg::*;
(
  input  logic [MAX_ORIGINAL_DATA_BITS-1:0]      raw,
  input  logic [message_head_reserved_width-1:0] rsv,
  output logic [MAX_MESSAGE_BITS-1:0]            msg
);

  q_raw_t rec;
  q_msg_t m;

  assign rec = q_raw_t'(raw);

  always_comb begin
    m                  = '0;
    m.participant_id   = rec.participant_id;
    m.message_category = rec.message_category;
    m.message_type     = rec.message_type;
    m.reserved         = rsv;
    m.security_symbol  = rec.security_symbol;
    m.expiration_block = rec.expiration_block;
    m.strike_price     = rec.strike_price;
    m.bid_price        = rec.bid_price;
    m.bid_size         = rec.bid_size;
    m.offer_price      = rec.offer_price;
    m.offer_size       = rec.offer_size;
  end

  assign msg = m;

endmodule

// File: rtl/stage2_q_pack_arb.sv
// N-channel quote packer: per-channel FIFOs, round-robin merge, registered output stream.
// Optional macro STAGE2_Q_SEQ_NUM_EN puts a message sequence number in the reserved head field.
module stage2_q_pack_arb
  import stage2_q_pack_arb_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CH_W  = 2,
  parameter int CNT_W = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_CH-1:0]                      in_valid,
  output logic [N_CH-1:0]                      in_ready,
  input  logic [N_CH*MAX_ORIGINAL_DATA_BITS-1:0] in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [MAX_MESSAGE_BITS-1:0]          out_data,
  output logic [CH_W-1:0]                      out_ch,
  output logic [CNT_W-1:0]                     msg_cnt
);

  // valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
  // once valid is raised, it and its data stay stable until that transfer edge.

  localparam int RAW_W   = MAX_ORIGINAL_DATA_BITS;
  localparam int MSG_W   = MAX_MESSAGE_BITS;
  localparam int RSV_W   = message_head_reserved_width;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int FCNT_W  = $clog2(DEPTH + 1);

  logic [N_CH-1:0]  elig;
  logic [N_CH-1:0]  pop;
  logic [MSG_W-1:0] packed_msg [N_CH];
  logic [RSV_W-1:0] rsv_val;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  grant;
  logic             grant_vld;
  logic             load;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [RAW_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] fifo_cnt;
    logic              wr_en;
    logic              wr_d;

    assign in_ready[i] = (fifo_cnt != FCNT_W'(DEPTH));
    assign wr_en       = in_valid[i] & in_ready[i];
    // The entry written on the last edge is held back one cycle so arbitration sees
    // only settled storage; this is what sets the two-edge input-to-output latency.
    assign elig[i]     = (fifo_cnt > FCNT_W'(wr_d));
    assign pop[i]      = load & grant_vld & (grant == CH_W'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
        wr_d     <= 1'b0;
      end else begin
        wr_d <= wr_en;
        if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop[i]) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({wr_en, pop[i]})
          2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
          2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
          default: fifo_cnt <= fifo_cnt;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= in_data[i*RAW_W +: RAW_W];
    end

    stage2_q_field_pack u_pack (
      .raw (mem[rd_ptr]),
      .rsv (rsv_val),
      .msg (packed_msg[i])
    );
  end

  // First eligible channel at or after rr_ptr; scanning downward lets the nearest win.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (elig[(int'(rr_ptr) + k) % N_CH]) begin
        grant_vld = 1'b1;
        grant     = CH_W'((int'(rr_ptr) + k) % N_CH);
      end
    end
  end

  assign load = !out_valid || out_ready;

`ifdef STAGE2_Q_SEQ_NUM_EN
  logic [RSV_W-1:0] seq_cnt;

  // A load with out_valid high also retires the current message this edge,
  // so the incoming one takes the next number.
  assign rsv_val = seq_cnt + RSV_W'(out_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_cnt <= '0;
    end else if (out_valid && out_ready) begin
      seq_cnt <= seq_cnt + RSV_W'(1);
    end
  end
`else
  assign rsv_val = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
      msg_cnt   <= '0;
    end else begin
      if (load) begin
        out_valid <= grant_vld;
        if (grant_vld) begin
          out_data <= packed_msg[grant];
          out_ch   <= grant;
          rr_ptr   <= (grant == CH_W'(N_CH - 1)) ? '0 : grant + CH_W'(1);
        end
      end
      if (out_valid && out_ready) msg_cnt <= msg_cnt + CNT_W'(1);
    end
  end

endmodule
